// File: rtl/ram_bank.sv
// ram_bank: single-port synchronous RAM with per-byte write enables, 1- or 2-cycle
// read latency and a post-reset clear engine. Optional per-byte parity: `define RAM_PARITY_EN.
module ram_bank #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DEPTH          = 256,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    write_enable,
    input  logic                    read_enable,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid
`ifdef RAM_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             clearing;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] wr_idx;
    logic             acc_wr;
    logic             acc_rd;
    logic             rd_v1_q;
    logic [DATA_WIDTH-1:0] rd_s1;
`ifdef RAM_PARITY_EN
    logic [NB-1:0]    par_mm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        clearing = 1'b0;
        case (state_q)
            ST_CLEAR: clearing = (CLEAR_ON_RESET != 0);
            ST_IDLE:  ready    = 1'b1;
            default:  ;
        endcase
    end

    assign in_range = ({1'b0, address} < DEPTH_X);
    assign idx      = address[IDX_W-1:0];
    assign acc_wr   = ready & write_enable & in_range;
    assign acc_rd   = ready & read_enable;
    assign wr_idx   = clearing ? clr_cnt_q : idx;

    // Each byte lane is its own array so per-byte enables map onto plain memories;
    // the read register samples before the write lands, giving read-first behaviour.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;
        logic       lane_we;
        logic [7:0] lane_wd;

        assign lane_we = clearing | (acc_wr & byte_en[gi]);
        assign lane_wd = clearing ? 8'h00 : data_in[8*gi +: 8];

        always_ff @(posedge clk) begin
            if (lane_we) begin
                mem_q[wr_idx] <= lane_wd;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (acc_rd) begin
                rd_q <= in_range ? mem_q[idx] : 8'h00;
            end
        end

        assign rd_s1[8*gi +: 8] = rd_q;

`ifdef RAM_PARITY_EN
        logic par_mem_q [DEPTH];
        logic par_rd_q;

        always_ff @(posedge clk) begin
            if (lane_we) begin
                par_mem_q[wr_idx] <= ^lane_wd;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                par_rd_q <= 1'b0;
            end else if (acc_rd) begin
                par_rd_q <= in_range ? par_mem_q[idx] : 1'b0;
            end
        end

        assign par_mm[gi] = (^rd_q) != par_rd_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= acc_rd;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_v1_q;
                if (rd_v1_q) begin
                    dout_q <= rd_s1;
                end
            end
        end

        assign data_out   = dout_q;
        assign read_valid = vld_q;

`ifdef RAM_PARITY_EN
        logic perr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                perr_q <= 1'b0;
            end else begin
                perr_q <= rd_v1_q & (|par_mm);
            end
        end

        assign parity_err = perr_q;
`endif
    end else begin : g_lat1
        assign data_out   = rd_s1;
        assign read_valid = rd_v1_q;
`ifdef RAM_PARITY_EN
        assign parity_err = rd_v1_q & (|par_mm);
`endif
    end

endmodule
